cistercian_scan_controller: RTL
===============================

Name: cistercian_scan_controller

Overview:
- Time-multiplexes one 4-quadrant Cistercian numeral (units, tens, hundreds, thousands) onto a single shared dual Cistercian decoder.
- Drives the decoder's two digit channels plus BI/LT controls, and a one-hot pair-select for the lower glyph pair (units/tens) and the upper glyph pair (hundreds/thousands).
- Accepts new values through a load handshake and applies them only at frame boundaries, so no frame ever mixes old and new digits.
- Inserts blanking between pair changeovers to prevent ghosting.

Parameters:
- DWELL, 1000, cycles each pair is shown (1..65535)
- BLANK, 16, blanking cycles before each pair (1..65535)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset; synchronous, active-high
- EN  in  1  scan enable
- LD  in  1  load request; accepted when LD & RDY
- DIN  in  16  value; [3:0] units, [7:4] tens, [11:8] hundreds, [15:12] thousands
- RDY  out  1  pending slot empty (combinational, = !PV)
- LTREQ  in  1  lamp-test request, sampled at frame boundary
- N1  out  4  digit to decoder channel 1
- N2  out  4  digit to decoder channel 2
- LT1  out  1  lamp test channel 1, active-low
- LT2  out  1  lamp test channel 2, active-low
- BI  out  1  blanking to decoder, active-low
- SEL  out  2  one-hot pair select; 01 lower, 10 upper, 00 none
- FRM  out  1  one-cycle frame-start strobe

Behaviour:
- Internal state:
  - DISP: 16-bit shown value.
  - PEND + PV: pending value and its valid flag.
  - LTF: lamp-test flag for the current frame.
  - FSM state.
  - 16-bit down-counter CNT.
- All outputs except RDY are registered.
- Reset (RST=1 at an edge) forces:
  - state IDLE; DISP=0, PV=0, LTF=0
  - N1=N2=0, BI=0, SEL=00, LT1=LT2=1, FRM=0
  - RDY=1 from the first cycle after reset.
- RST overrides EN, LD and LTREQ, including in the middle of a frame.
- Load handshake:
  - When LD & RDY at an edge: PEND<=DIN, PV<=1, so RDY=0 next cycle.
  - LD while RDY=0 is ignored.
- Frame boundary: the edge entering BLANK0, either from IDLE with EN=1 or from SHOW1 at expiry. At that edge:
  - If PV: DISP<=PEND, PV<=0. A load accepted on this same edge is held in PEND for the next boundary.
  - LTF<=LTREQ.
  - FRM<=1 for that one cycle.
- FSM: IDLE -> BLANK0 -> SHOW0 -> BLANK1 -> SHOW1 -> BLANK0 ...
  - CNT loads BLANK-1 or DWELL-1 on state entry.
  - The state advances on the edge where CNT==0.
  - Each BLANK state lasts exactly BLANK cycles and each SHOW state exactly DWELL cycles.
  - Frame period = 2*(BLANK+DWELL) cycles.
- Outputs per state:
  - IDLE: BI=0, SEL=00, N1/N2 hold.
  - BLANK0: BI=0, SEL=00, N1=DISP[3:0], N2=DISP[7:4]. Digits are set on entry so they settle while blanked.
  - SHOW0: BI=1, SEL=01, N1/N2 hold.
  - BLANK1: BI=0, SEL=00, N1=DISP[11:8], N2=DISP[15:12].
  - SHOW1: BI=1, SEL=10.
  - LT1=LT2=!LTF in all non-IDLE states; 1 in IDLE.
- EN=0 at any edge: next state is IDLE (BI=0, SEL=00, FRM=0). PEND/PV are preserved and loads are still accepted.
- EN rising while in IDLE: the next edge is a frame boundary into BLANK0.
- SEL and BI=1 never overlap a digit change; SEL is never 11.

Optional Feature:
- Macro: CISTERCIAN_ZERO_SUPPRESS_EN
- Defined: if DISP[15:8]==0 and LTF=0, SHOW1 keeps BI=0 and SEL=00 for its DWELL cycles. Frame timing is unchanged. If LTF=1, SHOW1 behaves normally.
- Undefined: SHOW1 always drives BI=1 and SEL=10.

Test Plan:
- DWELL=4, BLANK=2, after reset: LD with DIN=16'h1234, then EN=1 ->
  - FRM=1 in the first BLANK0 cycle, with N1=4, N2=3, BI=0.
  - SHOW0 for 4 cycles with SEL=01, BI=1.
  - BLANK1 for 2 cycles with N1=2, N2=1.
  - SHOW1 for 4 cycles with SEL=10.
  - FRM repeats every 12 cycles.
- While 16'h1234 is shown: LD with DIN=16'hABCD mid-SHOW0, then LD with DIN=16'h5555 while RDY=0 ->
  - RDY=0 next cycle; the current frame finishes with digits 2/1.
  - The next frame shows D/C then B/A; 16'h5555 never appears.
  - RDY=1 after the boundary.
- LTREQ=1 asserted mid-frame ->
  - LT1/LT2 stay 1 until the next FRM.
  - Then LT1=LT2=0 for the whole frame while N1/N2 sequence unchanged.
- EN=0 during SHOW0 ->
  - Next cycle: BI=0, SEL=00, FRM=0.
  - EN=1 again -> the next cycle is BLANK0 with FRM=1.
- RST=1 during SHOW1 with PV=1 ->
  - Next cycle: N1=N2=0, BI=0, SEL=00, LT1=LT2=1, RDY=1.
  - Re-enabling shows 0/0 digits.
- DIN=16'h0042:
  - With CISTERCIAN_ZERO_SUPPRESS_EN, SHOW1 cycles have BI=0, SEL=00.
  - Without it, SHOW1 cycles have BI=1, SEL=10, N1=N2=0.
  - Frame period is 12 cycles in both cases.

Source files
------------

// File: rtl/cistercian_scan_controller.sv
// Scans one 4-digit Cistercian numeral onto a shared dual decoder, pair by pair.
// Optional CISTERCIAN_ZERO_SUPPRESS_EN blanks the upper pair when it is all zero.
module cistercian_scan_controller #(
    parameter int unsigned DWELL = 1000,
    parameter int unsigned BLANK = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic        LD,
    input  logic [15:0] DIN,
    output logic        RDY,
    input  logic        LTREQ,
    output logic [3:0]  N1,
    output logic [3:0]  N2,
    output logic        LT1,
    output logic        LT2,
    output logic        BI,
    output logic [1:0]  SEL,
    output logic        FRM
);

    typedef enum logic [2:0] {
        IDLE,
        BLANK0,
        SHOW0,
        BLANK1,
        SHOW1
    } state_t;

    localparam logic [15:0] BLANK_LD = 16'(BLANK - 1);
    localparam logic [15:0] DWELL_LD = 16'(DWELL - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] disp;
    logic [15:0] pend;
    logic        pv;
    logic        ltf;

    logic        expired;
    logic        boundary;
    logic [15:0] next_disp;
    logic        zs;

    assign RDY = !pv;

    always_comb begin
        expired   = (cnt == 16'd0);
        boundary  = EN && ((state == IDLE) || ((state == SHOW1) && expired));
        next_disp = pv ? pend : disp;
    end

`ifdef CISTERCIAN_ZERO_SUPPRESS_EN
    assign zs = (disp[15:8] == 8'h00) && !ltf;
`else
    assign zs = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= 16'd0;
            disp  <= 16'd0;
            pend  <= 16'd0;
            pv    <= 1'b0;
            ltf   <= 1'b0;
            N1    <= 4'd0;
            N2    <= 4'd0;
            BI    <= 1'b0;
            SEL   <= 2'b00;
            LT1   <= 1'b1;
            LT2   <= 1'b1;
            FRM   <= 1'b0;
        end else begin
            FRM <= 1'b0;

            // Boundary consumes a held value; a new load only lands when empty.
            if (boundary && pv) begin
                pv <= 1'b0;
            end else if (LD && !pv) begin
                pend <= DIN;
                pv   <= 1'b1;
            end

            if (!EN) begin
                state <= IDLE;
                BI    <= 1'b0;
                SEL   <= 2'b00;
                LT1   <= 1'b1;
                LT2   <= 1'b1;
            end else if (boundary) begin
                state <= BLANK0;
                cnt   <= BLANK_LD;
                disp  <= next_disp;
                ltf   <= LTREQ;
                N1    <= next_disp[3:0];
                N2    <= next_disp[7:4];
                BI    <= 1'b0;
                SEL   <= 2'b00;
                LT1   <= !LTREQ;
                LT2   <= !LTREQ;
                FRM   <= 1'b1;
            end else if (!expired) begin
                cnt <= cnt - 16'd1;
            end else begin
                unique case (state)
                    BLANK0: begin
                        state <= SHOW0;
                        cnt   <= DWELL_LD;
                        BI    <= 1'b1;
                        SEL   <= 2'b01;
                    end
                    SHOW0: begin
                        state <= BLANK1;
                        cnt   <= BLANK_LD;
                        BI    <= 1'b0;
                        SEL   <= 2'b00;
                        N1    <= disp[11:8];
                        N2    <= disp[15:12];
                    end
                    BLANK1: begin
                        state <= SHOW1;
                        cnt   <= DWELL_LD;
                        BI    <= !zs;
                        SEL   <= zs ? 2'b00 : 2'b10;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
